// File: rtl/ram_1rw_hs.sv
// Parameterised single-port RAM with valid/ready request and response handshakes.
// A sequenced clear engine zeroes the array after reset or on demand, so storage carries no reset.
module ram_1rw_hs #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int DEPTH  = 256,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    output logic              o_busy,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic [STRB_W-1:0] i_req_strb,
    input  logic              i_req_write,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [PTR_W-1:0]  idx;
    logic              wr_fire;
    logic              rd_fire;

    // Addresses at or beyond DEPTH are accepted but never touch the array.
    assign in_range = ({1'b0, i_req_addr} < (ADDR_W + 1)'(DEPTH));
    assign idx      = i_req_addr[PTR_W-1:0];
    assign wr_fire  = i_req_valid && o_req_ready && i_req_write;
    assign rd_fire  = i_req_valid && o_req_ready && !i_req_write;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (i_clear) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_busy      = 1'b0;
        o_req_ready = 1'b0;
        unique case (state_q)
            ST_CLEAR: o_busy = 1'b1;
            ST_RUN:   o_req_ready = !o_rsp_valid || i_rsp_ready;
            default:  o_busy = 1'b1;
        endcase
    end

    // Clear writes and request writes never coincide: requests are only accepted in RUN.
    always_ff @(posedge i_clk) begin
        if (state_q == ST_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (wr_fire && in_range) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_req_strb[b]) begin
                    mem[idx][8*b +: 8] <= i_req_data[8*b +: 8];
                end
            end
        end
    end

    // Response register is independent of the FSM so a pending response drains through CLEAR.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else if (rd_fire) begin
            o_rsp_valid <= 1'b1;
            o_rsp_data  <= in_range ? mem[idx] : '0;
        end else if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_1rw_hs.sv
// Self-checking bench for ram_1rw_hs: randomized traffic checked against a
// word-array reference model, plus directed clear, backpressure and range scenarios.
module tb_ram_1rw_hs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int STRB_W = DATA_W / 8;
    localparam int TMO    = 2000;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b1;
    logic              clear     = 1'b0;
    logic              busy;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_data  = '0;
    logic [STRB_W-1:0] req_strb  = '0;
    logic              req_write = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] model [DEPTH];

    ram_1rw_hs #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .o_busy     (busy),
        .i_req_addr (req_addr),
        .i_req_data (req_data),
        .i_req_strb (req_strb),
        .i_req_write(req_write),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .o_rsp_data (rsp_data),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] byte_mask(input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m = '0;
        for (int b = 0; b < STRB_W; b++)
            if (s[b]) m = m | (DATA_W'(8'hFF) << (8 * b));
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] a);
        if (int'(a) < DEPTH) return model[a];
        return '0;
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [STRB_W-1:0] s);
        logic [DATA_W-1:0] m = byte_mask(s);
        if (int'(a) < DEPTH) model[a] = (model[a] & ~m) | (d & m);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        bit ok = 1'b0;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        req_valid = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            if (wr) model_write(a, d, s);
        end else begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_timeout: req_ready=%b required 1 within %0d cycles", req_ready, TMO);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int busy_cycles = 0;
        int ready_bad   = 0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: busy=%b ready=%b rsp_valid=%b rsp_data=%h required 1 0 0 0",
                     busy, req_ready, rsp_valid, rsp_data);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            busy_cycles++;
            if (req_ready !== 1'b0) ready_bad++;
        end
        tests_run++;
        if (busy_cycles != DEPTH) begin
            tests_failed++;
            $display("FAIL reset_clear_len: busy cycles=%0d required %0d", busy_cycles, DEPTH);
        end
        tests_run++;
        if (ready_bad != 0) begin
            tests_failed++;
            $display("FAIL reset_ready_low: ready high in %0d busy cycles, required 0", ready_bad);
        end
        model_clear();
        step();
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, ADDR_W'(a), '0, '0);
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
                tests_failed++;
                $display("FAIL cleared_read addr=%0d: valid=%b data=%h required 1 %h", a, rsp_valid, rsp_data, 32'h0);
            end
            step();
        end
    endtask

    task automatic test_strobe_merge();
        issue(1'b1, 8'd3, 32'hDEADBEEF, 4'hF);
        issue(1'b1, 8'd3, 32'h11223344, 4'b0101);
        issue(1'b0, 8'd3, '0, '0);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDE22BE44) begin
            tests_failed++;
            $display("FAIL strobe_merge: valid=%b data=%h required 1 de22be44", rsp_valid, rsp_data);
        end
        step();
        issue(1'b1, 8'd3, 32'hFFFFFFFF, 4'h0);
        issue(1'b0, 8'd3, '0, '0);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDE22BE44) begin
            tests_failed++;
            $display("FAIL strobe_zero_noop: valid=%b data=%h required 1 de22be44", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] v = $urandom;
        int bad = 0;
        issue(1'b1, 8'd5, v, 4'hF);
        rsp_ready = 1'b0;
        issue(1'b0, 8'd5, '0, '0);
        req_write = 1'b1;
        req_addr  = 8'd5;
        req_data  = ~v;
        req_strb  = 4'hF;
        req_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== v || req_ready !== 1'b0) bad++;
            step();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d of 4 stalled cycles wrong, required 0", bad);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ready_return: req_ready=%b required 1", req_ready);
        end
        step();
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== v) begin
            tests_failed++;
            $display("FAIL bp_drain: valid=%b data=%h required 0 %h", rsp_valid, rsp_data, v);
        end
        step();
        issue(1'b0, 8'd5, '0, '0);
        @(negedge clk);
        tests_run++;
        if (rsp_data !== v) begin
            tests_failed++;
            $display("FAIL bp_stalled_write_ignored: data=%h required %h", rsp_data, v);
        end
        step();
    endtask

    task automatic test_out_of_range();
        int bad = 0;
        issue(1'b1, 8'd250, 32'h000000AA, 4'hF);
        issue(1'b0, 8'd250, '0, '0);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL oor_read: valid=%b data=%h required 1 0", rsp_valid, rsp_data);
        end
        step();
        for (int a = 0; a < DEPTH; a++) begin
            issue(1'b0, ADDR_W'(a), '0, '0);
            @(negedge clk);
            if (rsp_data !== exp_rd(ADDR_W'(a))) bad++;
            step();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL oor_array_intact: %0d entries changed, required 0", bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] a = ADDR_W'($urandom_range(0, 255));
            logic [DATA_W-1:0] d = $urandom;
            logic [STRB_W-1:0] s = STRB_W'($urandom_range(0, 15));
            logic [DATA_W-1:0] e;
            if ($urandom_range(0, 1) == 1) begin
                issue(1'b1, a, d, s);
            end else begin
                e = exp_rd(a);
                issue(1'b0, a, '0, '0);
                @(negedge clk);
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_data !== e) begin
                    tests_failed++;
                    $display("FAIL random_read addr=%0d: valid=%b data=%h required 1 %h", a, rsp_valid, rsp_data, e);
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < 8; i++) issue(1'b1, ADDR_W'(i), DATA_W'(i * 3), 4'hF);
        req_write = 1'b0;
        req_addr  = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b1) bad++;
            if (i > 0 && (rsp_valid !== 1'b1 || rsp_data !== DATA_W'((i - 1) * 3))) bad++;
            step();
            req_addr = ADDR_W'(i + 1);
            if (i == 7) req_valid = 1'b0;
        end
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== DATA_W'(21)) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stream_reads: %0d bad cycles in 8-read stream, required 0", bad);
        end
        step();
    endtask

    task automatic test_clear();
        int cnt = 0;
        int held_bad = 0;
        logic [DATA_W-1:0] e7;
        issue(1'b1, 8'd7, 32'h0000005A, 4'h1);
        e7 = exp_rd(8'd7);
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'd7;
        req_valid = 1'b1;
        clear     = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_same_cycle_accept: req_ready=%b required 1", req_ready);
        end
        step();
        clear     = 1'b0;
        req_valid = 1'b0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
            if (cnt <= 3 && (rsp_valid !== 1'b1 || rsp_data !== e7 || req_ready !== 1'b0)) held_bad++;
            if (cnt == 3) begin
                step();
                rsp_ready = 1'b1;
            end
        end
        tests_run++;
        if (cnt != DEPTH) begin
            tests_failed++;
            $display("FAIL clear_len: busy cycles=%0d required %0d", cnt, DEPTH);
        end
        tests_run++;
        if (held_bad != 0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_pending_rsp: bad=%0d valid=%b required 0 0", held_bad, rsp_valid);
        end
        model_clear();
        step();
        issue(1'b0, 8'd7, '0, '0);
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL clear_zeroes: valid=%b data=%h required 1 0", rsp_valid, rsp_data);
        end
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (50) @(negedge clk);
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        cnt = 0;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
        tests_run++;
        if (cnt != DEPTH) begin
            tests_failed++;
            $display("FAIL clear_restart_len: busy cycles=%0d required %0d", cnt, DEPTH);
        end
        step();
    endtask

    task automatic test_reset_midtransfer();
        int cnt = 0;
        issue(1'b1, 8'd9, 32'hCAFEF00D, 4'hF);
        rsp_ready = 1'b0;
        issue(1'b0, 8'd9, '0, '0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== '0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b data=%h busy=%b ready=%b required 0 0 1 0",
                     rsp_valid, rsp_data, busy, req_ready);
        end
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cnt++;
        end
        model_clear();
        step();
        issue(1'b0, 8'd9, '0, '0);
        @(negedge clk);
        tests_run++;
        if (cnt != DEPTH || rsp_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_reclear: busy=%0d data=%h required %0d 0", cnt, rsp_data, DEPTH);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_strobe_merge();
        test_backpressure();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_midtransfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
